// File: rtl/workpiece_batch_ctrl_pkg.sv
// Shared definitions for the workpiece counting path.
// Also used by the 7-segment display scanner and the debug-LED decode.
//   state_t        FSM encoding driven on the 'state' debug output
//   BCD_DIGIT_MAX  largest legal BCD digit value
//   bcd_inc()      4-digit BCD increment with full ripple carry, 9999 -> 0000
package workpiece_batch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PACK = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // Digits are {thou,hund,ten,unit}. A digit at (or above) 9 rolls to 0
  // and passes the carry on, so 0999 -> 1000 and 9999 -> 0000 in one step.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] >= BCD_DIGIT_MAX) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/workpiece_batch_ctrl_sync.sv
// Detector conditioning: 2-flop synchroniser, tick-gated debounce and a
// one-clk pulse on an accepted high->low (workpiece arrived) transition.
//   clk   system clock
//   CR    synchronous active-high reset; idle level is 1 (no workpiece)
//   tick  sample strobe; the debounce only advances when tick=1
//   din   raw asynchronous detector, low = workpiece present
//   fall  one clk wide, the cycle after a 1->0 level is accepted
module wp_edge_sync #(
  parameter int DEB_LEN = 3
) (
  input  logic clk,
  input  logic CR,
  input  logic tick,
  input  logic din,
  output logic fall
);

  logic       sync1, sync2;
  logic       level;
  logic [2:0] run_len;

  always_ff @(posedge clk) begin
    if (CR) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      run_len <= '0;
      fall    <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      fall  <= 1'b0;
      if (tick) begin
        // Any sample agreeing with the accepted level restarts the run.
        if (sync2 == level) begin
          run_len <= '0;
        end else if (run_len == 3'(DEB_LEN - 1)) begin
          level   <= sync2;
          run_len <= '0;
          fall    <= ~sync2;
        end else begin
          run_len <= run_len + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/workpiece_batch_ctrl.sv
// Conveyor workpiece-counting sequencer.
// Counts debounced workpieces into a batch count and a 4-digit BCD total;
// a full batch stops the conveyor and runs a pack_req/pack_done handshake.
//   clk, CR        clock and synchronous active-high reset
//   tick           debounce sample strobe
//   detector       raw sensor, low = workpiece present
//   start, stop    one-clk operator pulses
//   pack_done      packer finished (level, held until pack_req drops)
//   conveyor_run   motor enable (RUN only)
//   pack_req       box-the-batch request (PACK only)
//   batch_cnt      workpieces in the current batch
//   total_bcd      running total {thou,hund,ten,unit}
//   state          FSM state for debug LEDs
module workpiece_batch_ctrl
  import workpiece_batch_ctrl_pkg::*;
#(
  parameter int BATCH_SIZE = 12,
  parameter int DEB_LEN    = 3
) (
  input  logic        clk,
  input  logic        CR,
  input  logic        tick,
  input  logic        detector,
  input  logic        start,
  input  logic        stop,
  input  logic        pack_done,
  output logic        conveyor_run,
  output logic        pack_req,
  output logic [7:0]  batch_cnt,
  output logic [15:0] total_bcd,
  output logic [1:0]  state
);

  localparam logic [7:0] BATCH_FULL = 8'(BATCH_SIZE);

  logic        wp_pulse;
  state_t      state_q, state_d;
  logic [7:0]  batch_q, batch_d;
  logic [15:0] total_q, total_d;
  logic        stop_lat_q, stop_lat_d;

  wp_edge_sync #(.DEB_LEN(DEB_LEN)) u_sync (
    .clk  (clk),
    .CR   (CR),
    .tick (tick),
    .din  (detector),
    .fall (wp_pulse)
  );

  always_ff @(posedge clk) begin
    if (CR) begin
      state_q    <= ST_IDLE;
      batch_q    <= '0;
      total_q    <= '0;
      stop_lat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      batch_q    <= batch_d;
      total_q    <= total_d;
      stop_lat_q <= stop_lat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    batch_d    = batch_q;
    total_d    = total_q;
    stop_lat_d = stop_lat_q;
    unique case (state_q)
      ST_IDLE: begin
        stop_lat_d = 1'b0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        stop_lat_d = 1'b0;
        if (wp_pulse) begin
          batch_d = batch_q + 8'd1;
          total_d = bcd_inc(total_q);
          // Filling the batch wins over a simultaneous stop; the stop is
          // kept so the line halts once the handshake completes.
          if (batch_d == BATCH_FULL) begin
            state_d    = ST_PACK;
            stop_lat_d = stop;
          end else if (stop) begin
            state_d = ST_IDLE;
          end
        end else if (stop) begin
          state_d = ST_IDLE;
        end
      end
      ST_PACK: begin
        if (stop) stop_lat_d = 1'b1;
        if (pack_done) begin
          state_d = ST_WAIT;
          batch_d = '0;
        end
      end
      ST_WAIT: begin
        if (stop) stop_lat_d = 1'b1;
        if (!pack_done) begin
          state_d    = (stop_lat_q || stop) ? ST_IDLE : ST_RUN;
          stop_lat_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign conveyor_run = (state_q == ST_RUN);
  assign pack_req     = (state_q == ST_PACK);
  assign batch_cnt    = batch_q;
  assign total_bcd    = total_q;
  assign state        = state_q;

endmodule
